// File: rtl/phaethon_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phaethon_uart_pkg
// Description : Shared types and line-level constants for the Phaethon UART
//               transmit path. The PARITY state exists only when the
//               UART_TX_PARITY_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package phaethon_uart_pkg;

  // Transmit FSM states; explicit encodings keep waveforms stable across builds
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_START    = 3'd3,
    ST_DATA     = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY   = 3'd5,
`endif
    ST_STOP     = 3'd6
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Free-running bit-period counter, 0..CLKS_PER_BIT-1. tick is
//               high on the terminal count; clear restarts the period so the
//               first bit of a new state gets its full width.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_count;

  // Count one bit period, restarting on terminal count or on state entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear || (r_count == c_TERM)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // tick depends only on the count register, never on clear, so the FSM can
  // derive clear from its next state without forming a loop
  assign tick = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Pops bytes from the RingBuffer read port and shifts each one
//               out as an asynchronous 8N1 frame (8E1 when UART_TX_PARITY_EN
//               is defined). All outputs are registered.
// Config      : UART_TX_PARITY_EN - insert an even-parity bit before stop
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import phaethon_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  txEnable,
  output logic                  readEnable,
  input  logic                  dataReadAck,
  input  logic [DATA_WIDTH-1:0] dataRead,
  output logic                  txd,
  output logic                  busy,
  output logic [31:0]           frameCount
);

  localparam int c_BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [c_BIT_W-1:0]    r_bit_idx;
  logic                  r_txd;
  logic                  r_read_en;
  logic                  r_busy;
  logic [31:0]           r_frame_count;
  logic                  w_tick;
  logic                  w_clear;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  // Restart the bit period whenever the FSM changes state
  assign w_clear      = (w_state_next != r_state);
  assign w_shift_next = r_shift >> 1;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Next-state decode; frame states advance only on the baud tick
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (txEnable) w_state_next = ST_REQ;
      ST_REQ:      w_state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: w_state_next = dataReadAck ? ST_START : ST_IDLE;
      ST_START:    if (w_tick) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_tick && (r_bit_idx == c_LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY:   if (w_tick) w_state_next = ST_STOP;
`endif
      ST_STOP: begin
        if (w_tick) w_state_next = txEnable ? ST_REQ : ST_IDLE;
      end
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // State, shift register and registered outputs; the line level for each
  // state is loaded on the edge that enters it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_txd         <= IDLE_LINE;
      r_read_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_read_en <= (w_state_next == ST_REQ);
      case (r_state)
        ST_WAIT_ACK: begin
          if (dataReadAck) begin
            r_shift   <= dataRead;
            r_bit_idx <= '0;
            r_txd     <= START_BIT;
            r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^dataRead;
`endif
          end
        end
        ST_START: begin
          if (w_tick) r_txd <= r_shift[0];
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_next;
            if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_txd <= r_parity;
`else
              r_txd <= STOP_BIT;
`endif
            end else begin
              r_txd     <= w_shift_next[0];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) r_txd <= STOP_BIT;
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_frame_count <= r_frame_count + 32'd1;
            r_busy        <= 1'b0;
            r_txd         <= IDLE_LINE;
          end
        end
        default: begin
          r_txd <= IDLE_LINE;
        end
      endcase
    end
  end

  assign txd        = r_txd;
  assign readEnable = r_read_en;
  assign busy       = r_busy;
  assign frameCount = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with a behavioural RingBuffer
//               read port and a scoreboard of expected bytes. Parity checks
//               are active when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int c_CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int c_NB = 11;
`else
  localparam int c_NB = 10;
`endif

  logic        clk;
  logic        reset;
  logic        txEnable;
  logic        readEnable;
  logic        dataReadAck;
  logic [7:0]  dataRead;
  logic        txd;
  logic        busy;
  logic [31:0] frameCount;

  logic [7:0]  buf_q[$];
  logic [7:0]  exp_q[$];
  logic        pend;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          exp_frames;

  uart_tx #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (c_CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .txEnable    (txEnable),
    .readEnable  (readEnable),
    .dataReadAck (dataReadAck),
    .dataRead    (dataRead),
    .txd         (txd),
    .busy        (busy),
    .frameCount  (frameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used for gap and spacing measurements
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog: stop a runaway simulation
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // RingBuffer read port: ack one cycle after readEnable when data is present
  initial begin
    dataReadAck = 1'b0;
    dataRead    = 8'h00;
    pend        = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dataReadAck = 1'b0;
      if (pend && (buf_q.size() > 0)) begin
        dataReadAck = 1'b1;
        dataRead    = buf_q.pop_front();
      end
      pend = readEnable;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    buf_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture one frame from txd, sampled every cycle, and score it.
  // drop_at >= 0 deasserts txEnable at that cycle offset into the frame.
  task automatic rx_frame(input int drop_at, output int s_cyc, output int e_cyc);
    logic [10:0] bits;
    logic [7:0]  exp_b;
    logic        stable;
    logic        prev_busy;
    int          busy_cnt;
    int          waitn;
    waitn     = 0;
    prev_busy = 1'b0;
    while ((txd !== 1'b0) && (waitn < 3000)) begin
      prev_busy = busy;
      step();
      waitn++;
    end
    if (txd !== 1'b0) begin
      chk("rx_start_timeout", 32'd0, 32'd1);
      s_cyc = cyc;
      e_cyc = cyc;
      return;
    end
    chk("busy_before_start", {31'd0, prev_busy}, 32'd0);
    s_cyc    = cyc;
    stable   = 1'b1;
    busy_cnt = 0;
    bits     = '0;
    for (int i = 0; i < c_NB * c_CPB; i++) begin
      if (i == drop_at) txEnable = 1'b0;
      if ((i % c_CPB) == 0) bits[i / c_CPB] = txd;
      else if (txd !== bits[i / c_CPB]) stable = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (i != c_NB * c_CPB - 1) step();
    end
    e_cyc = cyc;
    if (exp_q.size() == 0) begin
      chk("rx_unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
      return;
    end
    exp_b = exp_q.pop_front();
    chk("start_bit", {31'd0, bits[0]}, 32'd0);
    chk("data_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
    chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^exp_b});
`endif
    chk("stop_bit", {31'd0, bits[c_NB-1]}, 32'd1);
    chk("bits_stable", {31'd0, stable}, 32'd1);
    chk("busy_cycles", busy_cnt, c_NB * c_CPB);
    exp_frames++;
  endtask

  initial begin
    int n, first, second, s0, e0, s1, e1;
    logic ok;
    n_checks   = 0;
    n_pass     = 0;
    exp_frames = 0;
    reset      = 1'b0;
    txEnable   = 1'b1;

    // Reset state while held
    repeat (4) step();
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_readEnable", {31'd0, readEnable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frameCount", frameCount, 32'd0);
    reset = 1'b1;

    // Empty buffer polling: one pulse every 3 cycles, line stays idle
    n = 0; first = -1; second = -1; ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (readEnable === 1'b1) begin
        n++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (txd !== 1'b1) ok = 1'b0;
    end
    chk("poll_count", n, 32'd10);
    chk("poll_spacing", second - first, 32'd3);
    chk("poll_txd_idle", {31'd0, ok}, 32'd1);
    chk("poll_frameCount", frameCount, 32'd0);

    // Single frame 0xA5
    push_byte(8'hA5);
    rx_frame(-1, s0, e0);
    step();
    chk("a5_frameCount", frameCount, exp_frames);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back streaming with a 2-cycle idle gap
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    rx_frame(-1, s0, e0);
    rx_frame(-1, s1, e1);
    chk("gap_1_2", s1 - e0 - 1, 32'd2);
    rx_frame(-1, s0, e0);
    chk("gap_2_3", s0 - e1 - 1, 32'd2);
    step();
    chk("stream_frameCount", frameCount, exp_frames);
    chk("stream_buffer_empty", buf_q.size(), 32'd0);

    // txEnable dropped during data bits: frame completes, no more pops
    push_byte(8'h55);
    push_byte(8'h66);
    rx_frame(14, s0, e0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (readEnable === 1'b1) n++;
    end
    chk("drop_no_readEnable", n, 32'd0);
    chk("drop_buffer_len", buf_q.size(), 32'd1);
    chk("drop_frameCount", frameCount, exp_frames);

    // Asynchronous reset during the 4th data bit of 0x66
    txEnable = 1'b1;
    n = 0;
    while ((txd !== 1'b0) && (n < 50)) begin
      step();
      n++;
    end
    chk("rst_frame_started", {31'd0, txd}, 32'd0);
    repeat (17) step();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_txd", {31'd0, txd}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_frameCount", frameCount, 32'd0);
    void'(exp_q.pop_front());
    exp_frames = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (readEnable !== 1'b0) n++;
    end
    chk("rst_held_no_readEnable", n, 32'd0);
    reset = 1'b1;

    // Recovery frame after reset, then parity-sensitive bytes
    push_byte(8'h3C);
    rx_frame(-1, s0, e0);
    step();
    chk("post_rst_frameCount", frameCount, exp_frames);
    push_byte(8'h07);
    push_byte(8'h03);
    rx_frame(-1, s0, e0);
    rx_frame(-1, s1, e1);
    step();
    chk("final_frameCount", frameCount, exp_frames);
    chk("final_scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial transmit stage that drains the RingBuffer: pops one byte at a time through the buffer's read port and shifts it out as an asynchronous 8N1 frame on a single line. It sits directly downstream of RingBuffer, driving its readEnable and consuming dataReadAck/dataRead. It is the byte sink for the Phaethon debug/console path.

## Interface
- DATA_WIDTH, 8, payload bits per frame; must match the RingBuffer data width
- CLKS_PER_BIT, 16, clk cycles per line bit; legal range ≥ 2
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset); applies immediately, release synchronous to clk
- txEnable  input  1  permits new pops; a frame already started always completes
- readEnable  output  1  to RingBuffer; one-cycle pop request
- dataReadAck  input  1  from RingBuffer; 1 = pop succeeded, valid the cycle after readEnable
- dataRead  input  DATA_WIDTH  from RingBuffer; byte, valid when dataReadAck = 1
- txd  output  1  serial line, idle high
- busy  output  1  high from first start-bit cycle to last stop-bit cycle inclusive
- frameCount  output  32  frames completed since reset

## Operation
- Reset values: txd = 1, readEnable = 0, busy = 0, frameCount = 0, state = IDLE, shift register = 0, baud counter = 0.
- States: IDLE, REQ, WAIT_ACK, START, DATA, PARITY (only if macro set), STOP.
- IDLE: if txEnable = 1 → REQ, else stay.
- REQ: readEnable = 1 for exactly this cycle → WAIT_ACK.
- WAIT_ACK: readEnable = 0; sample dataReadAck. 1 → latch dataRead into shift register, → START. 0 (buffer empty) → IDLE; no byte consumed, retry on the next IDLE evaluation.
- START: txd = 0 for CLKS_PER_BIT cycles → DATA.
- DATA: txd = shift[0], LSB first; each bit held CLKS_PER_BIT cycles; shift right after each bit; after DATA_WIDTH bits → PARITY or STOP.
- STOP: txd = 1 for CLKS_PER_BIT cycles; on final cycle frameCount increments (wraps 2^32−1 → 0); then → REQ if txEnable = 1, else IDLE.
- readEnable is never asserted outside REQ; at most one pop outstanding.
- txEnable deasserted mid-frame: frame finishes, no further REQ.
- Asynchronous reset mid-frame: txd returns to 1 immediately; the popped byte is discarded (not returned to the buffer); frameCount clears.
- Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT−1, bit advance at terminal count; reset to 0 on each state entry.

## Timing
- Pop latency: REQ cycle N, ack sampled at edge ending cycle N+1, txd falls in cycle N+2.
- Frame length: (2 + DATA_WIDTH) × CLKS_PER_BIT cycles (plus CLKS_PER_BIT with parity).
- Back-to-back streaming: exactly 2 idle-high cycles (REQ, WAIT_ACK) between a stop bit and the next start bit.
- Empty buffer polling: one readEnable pulse every 3 cycles (IDLE, REQ, WAIT_ACK) while txEnable = 1.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after DATA; txd = even parity (XOR of the DATA_WIDTH data bits) for CLKS_PER_BIT cycles; frame is 8E1.
- Not defined: PARITY state and parity logic absent; DATA → STOP; frame is 8N1.

## Structure
- Shared package phaethon_uart_pkg: state enum type, START_BIT = 1'b0, STOP_BIT = 1'b1, IDLE_LINE = 1'b1.
- One sub-module: uart_baud_counter (parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick on terminal count).

## Test plan
- Reset held, then released with empty buffer, txEnable = 1 → txd stays 1, readEnable pulses every 3rd cycle, dataReadAck = 0, frameCount = 0.
- CLKS_PER_BIT = 4, push 0xA5 → txd sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; frameCount = 1; busy high 40 cycles.
- Push 0x01, 0x02, 0x03 → three frames, exactly 2 idle cycles between stop and next start, frameCount = 3, buffer empty afterwards.
- txEnable dropped during the DATA bits of 0x55 → frame completes, no further readEnable, second queued byte stays in buffer (bufferLength = 1).
- Reset asserted during the 4th data bit → txd = 1 immediately, frameCount = 0, no readEnable until reset released.
- With UART_TX_PARITY_EN, send 0x07 → parity bit = 1 before stop; send 0x03 → parity bit = 0; frame length 44 cycles at CLKS_PER_BIT = 4.
